// File: rtl/soc_mem_loader.sv
// Framed byte-stream image loader: parses CH/ADDR/LEN/payload/CSUM packets and
// writes the payload into one of NUM_CH word memories with little-endian byte strobes.
module soc_mem_loader #(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 14,
    localparam int BYTES  = DATA_W / 8,
    localparam int LANE_W = $clog2(BYTES),
    localparam int WA_W   = ADDR_W - LANE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic [NUM_CH-1:0] mem_we,
    output logic [WA_W-1:0]   mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BYTES-1:0]  mem_wstrb,
    output logic              load_active,
    output logic              done,
    output logic              error
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_HDR_ADDR = 3'd1;
    localparam logic [2:0] S_HDR_LEN  = 3'd2;
    localparam logic [2:0] S_DATA     = 3'd3;
    localparam logic [2:0] S_DRAIN    = 3'd4;
    localparam logic [2:0] S_CSUM     = 3'd5;
    localparam logic [2:0] S_RESP     = 3'd6;

    localparam logic [32:0] LIMIT  = 33'd1 << ADDR_W;
    localparam int          LANE_S = (LANE_W == 0) ? 1 : LANE_W;

    logic [2:0]        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [7:0]        ch_q, ch_d;
    logic [31:0]       addr_q, addr_d;
    logic [23:0]       len_q, len_d;
    logic [32:0]       rem_q, rem_d;
    logic [7:0]        sum_q, sum_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [BYTES-1:0]  strb_q, strb_d;
    logic [NUM_CH-1:0] we_q, we_d;
    logic [WA_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BYTES-1:0]  wstrb_q, wstrb_d;
    logic              active_q, active_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              xfer;
    logic [31:0]       len_full;
    logic [32:0]       end_addr;
    logic              hdr_fault;
    logic [LANE_S-1:0] lane;
    logic              lane_top;
    logic              last_byte;
    logic [DATA_W-1:0] buf_ins;
    logic [BYTES-1:0]  strb_ins;
    logic [NUM_CH-1:0] ch_onehot;

    assign s_ready     = reset && (state_q != S_RESP);
    assign xfer        = s_valid && s_ready;
    assign mem_we      = we_q;
    assign mem_addr    = waddr_q;
    assign mem_wdata   = wdata_q;
    assign mem_wstrb   = wstrb_q;
    assign load_active = active_q;
    assign done        = done_q;
    assign error       = error_q;

    // Range check uses 33-bit arithmetic so ADDR+LEN cannot wrap past the limit.
    assign len_full  = {s_data, len_q};
    assign end_addr  = {1'b0, addr_q} + {1'b0, len_full};
    assign hdr_fault = (ch_q >= 8'(NUM_CH)) || ({1'b0, addr_q} >= LIMIT) || (end_addr > LIMIT);

    generate
        if (LANE_W == 0) begin : g_lane_one
            assign lane = 1'b0;
        end else begin : g_lane_many
            assign lane = addr_q[LANE_S-1:0];
        end
    endgenerate

    assign lane_top  = (lane == LANE_S'(BYTES - 1));
    assign last_byte = (rem_q == 33'd1);

    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_ins
            assign buf_ins[8*gi +: 8] = (lane == LANE_S'(gi)) ? s_data : buf_q[8*gi +: 8];
            assign strb_ins[gi]       = (lane == LANE_S'(gi)) | strb_q[gi];
        end
        for (gi = 0; gi < NUM_CH; gi++) begin : g_we
            assign ch_onehot[gi] = (ch_q == 8'(gi));
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ch_d     = ch_q;
        addr_d   = addr_q;
        len_d    = len_q;
        rem_d    = rem_q;
        sum_d    = sum_q;
        buf_d    = buf_q;
        strb_d   = strb_q;
        we_d     = '0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        active_d = active_q;
        done_d   = 1'b0;
        error_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    ch_d     = s_data;
                    cnt_d    = 2'd0;
                    sum_d    = 8'd0;
                    buf_d    = '0;
                    strb_d   = '0;
                    active_d = 1'b1;
                    state_d  = S_HDR_ADDR;
                end
            end
            S_HDR_ADDR: begin
                if (xfer) begin
                    addr_d = {s_data, addr_q[31:8]};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_HDR_LEN;
                    end
                end
            end
            S_HDR_LEN: begin
                if (xfer) begin
                    len_d = {s_data, len_q[23:8]};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (hdr_fault) begin
                            rem_d   = {1'b0, len_full} + 33'd1;
                            state_d = S_DRAIN;
                        end else if (len_full == 32'd0) begin
                            state_d = S_CSUM;
                        end else begin
                            rem_d   = {1'b0, len_full};
                            state_d = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    sum_d  = sum_q + s_data;
                    addr_d = addr_q + 32'd1;
                    rem_d  = rem_q - 33'd1;
                    // Flush when the top lane fills or the payload ends mid-word.
                    if (lane_top || last_byte) begin
                        we_d    = ch_onehot;
                        waddr_d = addr_q[ADDR_W-1:LANE_W];
                        wdata_d = buf_ins;
                        wstrb_d = strb_ins;
                        buf_d   = '0;
                        strb_d  = '0;
                    end else begin
                        buf_d  = buf_ins;
                        strb_d = strb_ins;
                    end
                    if (last_byte) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_DRAIN: begin
                if (xfer) begin
                    rem_d = rem_q - 33'd1;
                    if (last_byte) begin
                        error_d = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    if (8'(sum_q + s_data) == 8'd0) begin
                        done_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                active_d = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ch_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            rem_q    <= '0;
            sum_q    <= '0;
            buf_q    <= '0;
            strb_q   <= '0;
            we_q     <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ch_q     <= ch_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            rem_q    <= rem_d;
            sum_q    <= sum_d;
            buf_q    <= buf_d;
            strb_q   <= strb_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            active_q <= active_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

endmodule

// File: tb/tb_soc_mem_loader.sv
// Directed bench for soc_mem_loader: drives packets byte by byte and checks writes,
// response pulses, header faults, reset abort and streaming throughput.
module tb_soc_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic [1:0]  mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        load_active;
    logic        done;
    logic        error;

    soc_mem_loader dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .load_active(load_active), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  we;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          cyc;
    } wr_t;

    wr_t wr_q[$];
    int  cyc = 0;
    int  done_cnt = 0;
    int  err_cnt = 0;
    int  nready_cnt = 0;
    int  total = 0;
    int  passes = 0;

    // Mid-cycle observer of the registered outputs.
    always @(negedge clk) begin
        if (mem_we != 2'b00) begin
            wr_t w;
            w.we = mem_we; w.addr = mem_addr; w.data = mem_wdata; w.strb = mem_wstrb; w.cyc = cyc;
            wr_q.push_back(w);
            $display("write ch_mask=%b addr=%0h data=%08h strb=%h cyc=%0d", mem_we, mem_addr, mem_wdata, mem_wstrb, cyc);
        end
        if (done === 1'b1) done_cnt++;
        if (error === 1'b1) err_cnt++;
        if (reset === 1'b1 && s_ready === 1'b0) nready_cnt++;
        cyc++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [49:0] wr_at(int i);
        if (i < wr_q.size()) return {wr_q[i].we, wr_q[i].addr, wr_q[i].data, wr_q[i].strb};
        return '1;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr();
        wr_q.delete();
        done_cnt = 0;
        err_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        s_valid = 1'b1;
        s_data  = b;
        while (s_ready !== 1'b1 && guard < 16) begin
            step(1);
            guard++;
        end
        if (guard >= 16) chk("s_ready_wait", 64'(s_ready), 64'd1);
        step(1);
        $display("byte %02h accepted", b);
    endtask

    task automatic send_hdr(input logic [7:0] ch, input logic [31:0] addr, input logic [31:0] len);
        send_byte(ch);
        for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
        for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8]);
    endtask

    task automatic send_pkt(input logic [7:0] ch, input logic [31:0] addr, input logic [31:0] len,
                            input logic [7:0] first, input logic [7:0] inc, input logic [7:0] csum);
        logic [7:0] b;
        send_hdr(ch, addr, len);
        b = first;
        for (int i = 0; i < int'(len); i++) begin
            send_byte(b);
            b = b + inc;
        end
        send_byte(csum);
    endtask

    // Called in the RESP cycle: checks the pulse and that load_active drops next cycle.
    task automatic chk_end(input string tag, input logic exp_done);
        chk({tag, "_done"}, 64'(done), 64'(exp_done));
        chk({tag, "_error"}, 64'(error), 64'(!exp_done));
        chk({tag, "_resp_busy"}, {62'd0, load_active, s_ready}, 64'b10);
        s_valid = 1'b0;
        step(1);
        chk({tag, "_after"}, {61'd0, load_active, done, error}, 64'd0);
    endtask

    initial begin
        reset = 1'b0;
        s_valid = 1'b0;
        s_data = 8'h00;
        step(3);
        chk("reset_outputs", 64'({s_ready, mem_we, mem_addr, mem_wdata, mem_wstrb, load_active, done, error}), 64'd0);
        reset = 1'b1;
        #1;
        chk("ready_after_release", 64'(s_ready), 64'd1);

        // Aligned load with a direct latency check on the first write.
        clr();
        send_byte(8'h00);
        chk("aln_active", 64'(load_active), 64'd1);
        for (int i = 0; i < 4; i++) send_byte(8'((32'h10 >> (8*i)) & 32'hFF));
        for (int i = 0; i < 4; i++) send_byte(8'((32'd8 >> (8*i)) & 32'hFF));
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        chk("aln_w0_latency", 64'({mem_we, mem_addr, mem_wdata, mem_wstrb}), {14'd0, 2'b01, 12'd4, 32'h04030201, 4'hF});
        for (int i = 5; i <= 8; i++) send_byte(8'(i));
        send_byte(8'hDC);
        chk_end("aln", 1'b1);
        chk("aln_nwr", 64'(wr_q.size()), 64'd2);
        chk("aln_w1", 64'(wr_at(1)), {14'd0, 2'b01, 12'd5, 32'h08070605, 4'hF});

        // Unaligned start and partial final word on channel 1.
        clr();
        send_pkt(8'd1, 32'h3, 32'd3, 8'hAA, 8'h11, 8'hCF);
        chk_end("una", 1'b1);
        chk("una_nwr", 64'(wr_q.size()), 64'd2);
        chk("una_w0", 64'(wr_at(0)), {14'd0, 2'b10, 12'd0, 32'hAA000000, 4'h8});
        chk("una_w1", 64'(wr_at(1)), {14'd0, 2'b10, 12'd1, 32'h0000CCBB, 4'h3});

        // Bad checksum: writes still land, error pulse.
        clr();
        send_pkt(8'd0, 32'h10, 32'd8, 8'h01, 8'h01, 8'h00);
        chk_end("bad", 1'b0);
        chk("bad_nwr", 64'(wr_q.size()), 64'd2);
        chk("bad_w0", 64'(wr_at(0)), {14'd0, 2'b01, 12'd4, 32'h04030201, 4'hF});

        // Bad channel: exactly LEN+1 bytes drained.
        clr();
        send_hdr(8'd5, 32'h0, 32'd4);
        for (int i = 0; i < 4; i++) send_byte(8'h5A);
        chk("ch_drain_pending", {62'd0, error, s_ready}, 64'b01);
        send_byte(8'h5A);
        chk_end("ch", 1'b0);
        chk("ch_nwr", 64'(wr_q.size()), 64'd0);

        // Address range overflow.
        clr();
        send_hdr(8'd0, 32'h3FFC, 32'd8);
        for (int i = 0; i < 8; i++) send_byte(8'hFF);
        chk("ovf_drain_pending", {62'd0, error, s_ready}, 64'b01);
        send_byte(8'hFF);
        chk_end("ovf", 1'b0);
        chk("ovf_nwr", 64'(wr_q.size()), 64'd0);

        // Recovery after fault.
        clr();
        send_pkt(8'd0, 32'h20, 32'd4, 8'h11, 8'h11, 8'h56);
        chk_end("rec", 1'b1);
        chk("rec_nwr", 64'(wr_q.size()), 64'd1);
        chk("rec_w0", 64'(wr_at(0)), {14'd0, 2'b01, 12'd8, 32'h44332211, 4'hF});

        // Zero-length packet.
        clr();
        send_pkt(8'd1, 32'h0, 32'd0, 8'h00, 8'h00, 8'h00);
        chk_end("len0", 1'b1);
        chk("len0_nwr", 64'(wr_q.size()), 64'd0);

        // Reset mid-payload, with a partial word pending.
        clr();
        send_hdr(8'd0, 32'h40, 32'd8);
        for (int i = 0; i < 3; i++) send_byte(8'h77);
        s_valid = 1'b0;
        reset = 1'b0;
        step(1);
        chk("abort_outputs", 64'({s_ready, mem_we, mem_addr, mem_wdata, mem_wstrb, load_active, done, error}), 64'd0);
        step(2);
        reset = 1'b1;
        step(1);
        chk("abort_no_pulse", 64'({done_cnt[15:0], err_cnt[15:0], 16'(wr_q.size())}), 64'd0);
        send_pkt(8'd1, 32'h8, 32'd4, 8'h01, 8'h01, 8'hF6);
        chk_end("fresh", 1'b1);
        chk("fresh_nwr", 64'(wr_q.size()), 64'd1);
        chk("fresh_w0", 64'(wr_at(0)), {14'd0, 2'b10, 12'd2, 32'h04030201, 4'hF});

        // Streaming 64 bytes with s_valid held high.
        clr();
        nready_cnt = 0;
        send_pkt(8'd1, 32'h100, 32'd64, 8'h00, 8'h01, 8'h20);
        chk_end("strm", 1'b1);
        step(1);
        chk("strm_nready", 64'(nready_cnt), 64'd1);
        chk("strm_nwr", 64'(wr_q.size()), 64'd16);
        for (int i = 0; i < 16; i++) begin
            logic [31:0] exp_data;
            exp_data = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
            chk($sformatf("strm_w%0d", i), 64'(wr_at(i)), {14'd0, 2'b10, 12'(64 + i), exp_data, 4'hF});
            if (i > 0 && i < wr_q.size()) chk($sformatf("strm_gap%0d", i), 64'(wr_q[i].cyc - wr_q[i-1].cyc), 64'd4);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
